// File: rtl/led_trail_pwm_if.sv
// Bus between the chase stage/pads and the comet-trail PWM block.
// master drives enable and pattern; slave (the PWM block) drives the LED outputs.
interface led_trail_pwm_if;
    logic       ena;
    logic [7:0] pattern_in;
    logic [7:0] pwm_out;
    logic [7:0] active_mask;
    logic       frame_start;

    modport master (
        output ena,
        output pattern_in,
        input  pwm_out,
        input  active_mask,
        input  frame_start
    );

    modport slave (
        input  ena,
        input  pattern_in,
        output pwm_out,
        output active_mask,
        output frame_start
    );
endinterface

// File: rtl/led_trail_pwm.sv
// Comet-trail PWM driver: lit LEDs run at full brightness, released LEDs fade linearly
// to off, and each channel's brightness is rendered as a frame-aligned PWM duty cycle.
module led_trail_pwm #(
    parameter int PWM_BITS      = 4,
    parameter int DECAY_DIV     = 50000,
    parameter int DECAY_STEP    = 1,
    parameter int IN_ACTIVE_LOW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    led_trail_pwm_if.slave  bus
);

    localparam int                  DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAXB     = '1;
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);
    localparam logic [7:0]          IN_XOR   = (IN_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [7:0]          pat_q, pat_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] brightness_q [8];
    logic [PWM_BITS-1:0] brightness_d [8];
    logic [PWM_BITS-1:0] duty_q [8];
    logic [PWM_BITS-1:0] duty_d [8];
    logic [7:0]          pwm_out_q, pwm_out_d;
    logic                frame_start_q, frame_start_d;
    logic                decay_tick;
    logic [7:0]          active_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q         <= '0;
            div_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            pwm_out_q     <= '0;
            frame_start_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                brightness_q[i] <= '0;
                duty_q[i]       <= '0;
            end
        end else begin
            pat_q         <= pat_d;
            div_cnt_q     <= div_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pwm_out_q     <= pwm_out_d;
            frame_start_q <= frame_start_d;
            brightness_q  <= brightness_d;
            duty_q        <= duty_d;
        end
    end

    always_comb begin
        pat_d         = pat_q;
        div_cnt_d     = div_cnt_q;
        pwm_cnt_d     = pwm_cnt_q;
        brightness_d  = brightness_q;
        duty_d        = duty_q;
        pwm_out_d     = '0;
        frame_start_d = 1'b0;
        decay_tick    = 1'b0;
        if (bus.ena) begin
            pat_d         = bus.pattern_in ^ IN_XOR;
            decay_tick    = (div_cnt_q == DIV_LAST);
            div_cnt_d     = decay_tick ? '0 : div_cnt_q + 1'b1;
            pwm_cnt_d     = pwm_cnt_q + 1'b1;
            frame_start_d = (pwm_cnt_q == MAXB);
            for (int i = 0; i < 8; i++) begin
                // A lit LED wins over a decay tick landing in the same cycle.
                if (pat_q[i]) begin
                    brightness_d[i] = MAXB;
                end else if (decay_tick) begin
                    brightness_d[i] = (int'(brightness_q[i]) > DECAY_STEP) ?
                                      brightness_q[i] - STEP : '0;
                end
                if (pwm_cnt_q == MAXB) begin
                    duty_d[i] = brightness_q[i];
                end
                // Compare against next-cycle duty/count so pwm_out lines up with frame_start.
                pwm_out_d[i] = (duty_d[i] == MAXB) || (duty_d[i] > pwm_cnt_d);
            end
        end
    end

    always_comb begin
        active_mask = '0;
        for (int i = 0; i < 8; i++) begin
            active_mask[i] = |brightness_q[i];
        end
    end

    assign bus.pwm_out     = pwm_out_q;
    assign bus.frame_start = frame_start_q;
    assign bus.active_mask = active_mask;

endmodule
